// File: rtl/game_pkg.sv
// Shared types and constants for the player/game blocks.
package game_pkg;

  typedef enum logic [1:0] {
    GROUND,
    RISE,
    HANG,
    FALL
  } jump_state_t;

  typedef logic [1:0] lane_t;

  localparam lane_t LANE_LEFT   = 2'd0;
  localparam lane_t LANE_CENTER = 2'd1;
  localparam lane_t LANE_RIGHT  = 2'd2;

endpackage

// File: rtl/debouncer.sv
// Two-flop synchronizer followed by a stability counter. The debounced
// level only follows the synchronized button once it has disagreed with
// the current level for DEBOUNCE_CYCLES consecutive cycles.
module debouncer #(
  parameter int DEBOUNCE_CYCLES = 65000
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic btn_in,
  output logic level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic          sync_meta;
  logic          sync_out;
  logic [CW-1:0] stable_cnt;

  // Bring the asynchronous button into the clk_in domain.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync_meta <= 1'b0;
      sync_out  <= 1'b0;
    end else begin
      sync_meta <= btn_in;
      sync_out  <= sync_meta;
    end
  end

  // Count how long the synchronized value has differed from the level; any return to the level restarts the count.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      stable_cnt <= '0;
      level      <= 1'b0;
    end else if (sync_out == level) begin
      stable_cnt <= '0;
    end else if (stable_cnt == CNT_MAX) begin
      level      <= sync_out;
      stable_cnt <= '0;
    end else begin
      stable_cnt <= stable_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/player_ctrl.sv
// Player front end: debounced buttons, lane selection and the frame-stepped
// jump arc that feed gamefsm and the renderer.
module player_ctrl #(
  parameter int DEBOUNCE_CYCLES = 65000,
  parameter int JUMP_HEIGHT     = 48,
  parameter int RISE_STEP       = 4,
  parameter int HANG_FRAMES     = 6
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       btn_left_in,
  input  logic       btn_right_in,
  input  logic       btn_jump_in,
  input  logic       frame_tick,
  input  logic       playing,
  input  logic       reset_game,
  output logic       jump,
  output logic [1:0] lane,
  output logic       airborne,
  output logic [6:0] height
);

  import game_pkg::*;

  localparam logic [6:0] STEP = 7'(RISE_STEP);
  localparam logic [6:0] APEX = 7'(JUMP_HEIGHT);
  localparam int HW = (HANG_FRAMES > 1) ? $clog2(HANG_FRAMES + 1) : 1;
  localparam logic [HW-1:0] HANG_LOAD = HW'(HANG_FRAMES - 1);

  logic          left_level;
  logic          right_level;
  logic          jump_level;
  logic [2:0]    level_prev;
  logic          left_rise;
  logic          right_rise;
  logic          jump_rise;

  jump_state_t   state;
  jump_state_t   state_next;
  logic [6:0]    height_next;
  logic [6:0]    height_up;
  logic [6:0]    height_down;
  logic [HW-1:0] hang_cnt;
  logic [HW-1:0] hang_next;

  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .btn_in   (btn_left_in),
    .level    (left_level)
  );

  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .btn_in   (btn_right_in),
    .level    (right_level)
  );

  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_jump (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .btn_in   (btn_jump_in),
    .level    (jump_level)
  );

  // Remember last cycle's debounced levels so 0->1 transitions give one-cycle pulses.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      level_prev <= 3'b000;
    end else begin
      level_prev <= {jump_level, right_level, left_level};
    end
  end

  assign left_rise  = left_level  & ~level_prev[0];
  assign right_rise = right_level & ~level_prev[1];
  assign jump_rise  = jump_level  & ~level_prev[2];

  assign height_up   = height + STEP;
  assign height_down = height - STEP;

  // Lane moves one step per edge while playing, clamped to 0..2; simultaneous left and right cancel.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      lane <= LANE_CENTER;
    end else if (reset_game) begin
      lane <= LANE_CENTER;
    end else if (playing && left_rise && !right_rise && (lane != LANE_LEFT)) begin
      lane <= lane - 2'd1;
    end else if (playing && right_rise && !left_rise && (lane != LANE_RIGHT)) begin
      lane <= lane + 2'd1;
    end
  end

  // Jump arc registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state    <= GROUND;
      height   <= 7'd0;
      hang_cnt <= '0;
    end else begin
      state    <= state_next;
      height   <= height_next;
      hang_cnt <= hang_next;
    end
  end

  // Jump arc next state: start from GROUND on a jump edge, then step once per frame tick.
  always_comb begin
    state_next  = state;
    height_next = height;
    hang_next   = hang_cnt;
    if (reset_game) begin
      state_next  = GROUND;
      height_next = 7'd0;
      hang_next   = '0;
    end else begin
      case (state)
        GROUND: begin
          if (playing && jump_rise) begin
            state_next = RISE;
          end
        end
        RISE: begin
          if (frame_tick) begin
            height_next = height_up;
            if (height_up == APEX) begin
              state_next = HANG;
              hang_next  = HANG_LOAD;
            end
          end
        end
        HANG: begin
          if (frame_tick) begin
            if (hang_cnt == '0) begin
              state_next = FALL;
            end else begin
              hang_next = hang_cnt - 1'b1;
            end
          end
        end
        FALL: begin
          if (frame_tick) begin
            height_next = height_down;
            if (height_down == 7'd0) begin
              state_next = GROUND;
            end
          end
        end
        default: begin
          state_next = GROUND;
        end
      endcase
    end
  end

  assign jump     = jump_level;
  assign airborne = (state != GROUND);

endmodule
